// File: rtl/cur_fetch_pkg.sv
// Shared types and constants for the current-block fetch unit.
// The 8x8 luma block geometry is fixed: 8 rows of 4 two-pixel words give 32 word slots.
package cur_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWaitSwap,
        StDrain
    } state_e;

    localparam int unsigned BlkRowPx    = 8;
    localparam int unsigned BlkRowWords = 4;
    localparam int unsigned BlkSlots    = BlkRowPx * BlkRowWords;

    localparam int unsigned FrameWWordsDef = 88;
    localparam int unsigned BlkColsDef     = 22;
    localparam int unsigned BlkRowsDef     = 18;
    localparam int unsigned AddrWDef       = 16;

endpackage

// File: rtl/cur_addr_gen.sv
// Block/row/word counters and incremental word-address arithmetic for block fetches.
// Row and block-row start addresses are kept in registers so no multiplier is needed.
module cur_addr_gen
    import cur_fetch_pkg::*;
#(
    parameter int unsigned FRAME_W_WORDS = FrameWWordsDef,
    parameter int unsigned BLK_COLS      = BlkColsDef,
    parameter int unsigned BLK_ROWS      = BlkRowsDef,
    parameter int unsigned ADDR_W        = AddrWDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              step_i,
    input  logic              next_blk_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [4:0]        slot_o,
    output logic              last_slot_o,
    output logic [4:0]        bx_o,
    output logic [4:0]        by_o,
    output logic              last_blk_o
);

    localparam logic [ADDR_W-1:0] RowStep    = ADDR_W'(FRAME_W_WORDS);
    localparam logic [ADDR_W-1:0] BlkRowStep = ADDR_W'(FRAME_W_WORDS * BlkRowPx);
    localparam logic [ADDR_W-1:0] ColStep    = ADDR_W'(BlkRowWords);
    localparam logic [1:0]        WordLast   = 2'(BlkRowWords - 1);
    localparam logic [4:0]        SlotLast   = 5'(BlkSlots - 1);
    localparam logic [4:0]        BxLast     = 5'(BLK_COLS - 1);
    localparam logic [4:0]        ByLast     = 5'(BLK_ROWS - 1);

    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] blk_row_base_q, blk_row_base_d;
    logic [ADDR_W-1:0] col_off_q, col_off_d;
    logic [1:0]        word_q, word_d;
    logic [2:0]        row_q, row_d;
    logic [4:0]        bx_q, bx_d;
    logic [4:0]        by_q, by_d;

    always_comb begin
        row_base_d     = row_base_q;
        blk_row_base_d = blk_row_base_q;
        col_off_d      = col_off_q;
        word_d         = word_q;
        row_d          = row_q;
        bx_d           = bx_q;
        by_d           = by_q;
        if (init_i) begin
            row_base_d     = base_addr_i;
            blk_row_base_d = base_addr_i;
            col_off_d      = '0;
            word_d         = '0;
            row_d          = '0;
            bx_d           = '0;
            by_d           = '0;
        end else if (next_blk_i) begin
            word_d = '0;
            row_d  = '0;
            if (bx_q == BxLast) begin
                bx_d           = '0;
                by_d           = by_q + 5'd1;
                col_off_d      = '0;
                blk_row_base_d = blk_row_base_q + BlkRowStep;
                row_base_d     = blk_row_base_q + BlkRowStep;
            end else begin
                bx_d       = bx_q + 5'd1;
                col_off_d  = col_off_q + ColStep;
                row_base_d = blk_row_base_q;
            end
        end else if (step_i) begin
            if (word_q == WordLast) begin
                word_d     = '0;
                row_d      = row_q + 3'd1;
                row_base_d = row_base_q + RowStep;
            end else begin
                word_d = word_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base_q     <= '0;
            blk_row_base_q <= '0;
            col_off_q      <= '0;
            word_q         <= '0;
            row_q          <= '0;
            bx_q           <= '0;
            by_q           <= '0;
        end else begin
            row_base_q     <= row_base_d;
            blk_row_base_q <= blk_row_base_d;
            col_off_q      <= col_off_d;
            word_q         <= word_d;
            row_q          <= row_d;
            bx_q           <= bx_d;
            by_q           <= by_d;
        end
    end

    assign addr_o      = row_base_q + col_off_q + ADDR_W'(word_q);
    assign slot_o      = {row_q, word_q};
    assign last_slot_o = (slot_o == SlotLast);
    assign bx_o        = bx_q;
    assign by_o        = by_q;
    assign last_blk_o  = (bx_q == BxLast) && (by_q == ByLast);

endmodule

// File: rtl/cur_fetch.sv
// Fetches 8x8 current blocks in raster order into a double-banked block register
// and hands each completed bank to the SAD stage via blk_ready/blk_done.
module cur_fetch
    import cur_fetch_pkg::*;
#(
    parameter int unsigned FRAME_W_WORDS = FrameWWordsDef,
    parameter int unsigned BLK_COLS      = BlkColsDef,
    parameter int unsigned BLK_ROWS      = BlkRowsDef,
    parameter int unsigned ADDR_W        = AddrWDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       data_out,
    output logic [4:0]        counter,
    output logic              ber,
    output logic              pause_out,
    output logic              blk_ready,
    input  logic              blk_done,
    output logic [4:0]        blk_x,
    output logic [4:0]        blk_y,
    output logic              busy,
    output logic              frame_done
);

    state_e      state_q, state_d;
    logic [15:0] data_out_q, data_out_d;
    logic [4:0]  counter_q, counter_d;
    logic        pause_q, pause_d;
    logic        ber_q, ber_d;
    logic        blk_ready_q, blk_ready_d;
    logic [4:0]  blk_x_q, blk_x_d;
    logic [4:0]  blk_y_q, blk_y_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic        gen_init, gen_step, gen_next_blk;
    logic [4:0]  gen_slot, gen_bx, gen_by;
    logic        gen_last_slot, gen_last_blk;

    cur_addr_gen #(
        .FRAME_W_WORDS (FRAME_W_WORDS),
        .BLK_COLS      (BLK_COLS),
        .BLK_ROWS      (BLK_ROWS),
        .ADDR_W        (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .init_i      (gen_init),
        .base_addr_i (base_addr),
        .step_i      (gen_step),
        .next_blk_i  (gen_next_blk),
        .addr_o      (mem_addr),
        .slot_o      (gen_slot),
        .last_slot_o (gen_last_slot),
        .bx_o        (gen_bx),
        .by_o        (gen_by),
        .last_blk_o  (gen_last_blk)
    );

    always_comb begin
        state_d      = state_q;
        data_out_d   = data_out_q;
        counter_d    = counter_q;
        pause_d      = 1'b1;
        ber_d        = ber_q;
        blk_ready_d  = blk_ready_q;
        blk_x_d      = blk_x_q;
        blk_y_d      = blk_y_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        gen_init     = 1'b0;
        gen_step     = 1'b0;
        gen_next_blk = 1'b0;
        mem_req      = 1'b0;

        if (blk_done && blk_ready_q) begin
            blk_ready_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gen_init = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = StFill;
                end
            end
            StFill: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    gen_step   = 1'b1;
                    data_out_d = mem_rdata;
                    counter_d  = gen_slot;
                    pause_d    = 1'b0;
                    if (gen_last_slot) begin
                        state_d = StWaitSwap;
                    end
                end
            end
            StWaitSwap: begin
                // pause_q low means slot 31 is being written now; the bank may not flip yet.
                if (pause_q && (!blk_ready_q || blk_done)) begin
                    ber_d       = ~ber_q;
                    blk_ready_d = 1'b1;
                    blk_x_d     = gen_bx;
                    blk_y_d     = gen_by;
                    if (gen_last_blk) begin
                        state_d = StDrain;
                    end else begin
                        gen_next_blk = 1'b1;
                        state_d      = StFill;
                    end
                end
            end
            StDrain: begin
                if (blk_done && blk_ready_q) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            data_out_q   <= '0;
            counter_q    <= '0;
            pause_q      <= 1'b1;
            ber_q        <= 1'b0;
            blk_ready_q  <= 1'b0;
            blk_x_q      <= '0;
            blk_y_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            counter_q    <= counter_d;
            pause_q      <= pause_d;
            ber_q        <= ber_d;
            blk_ready_q  <= blk_ready_d;
            blk_x_q      <= blk_x_d;
            blk_y_q      <= blk_y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_out   = data_out_q;
    assign counter    = counter_q;
    assign pause_out  = pause_q;
    assign ber        = ber_q;
    assign blk_ready  = blk_ready_q;
    assign blk_x      = blk_x_q;
    assign blk_y      = blk_y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cur_fetch.sv
// Directed bench for cur_fetch: a reference address/block model feeds a scoreboard of
// expected block-register writes, compared one cycle after each accepted read.
module tb_cur_fetch;

    localparam int FW = 88;
    localparam int BC = 22;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  slot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata;
    logic [15:0] data_out;
    logic [4:0]  counter;
    logic        ber;
    logic        pause_out;
    logic        blk_ready;
    logic        blk_done = 1'b0;
    logic [4:0]  blk_x;
    logic [4:0]  blk_y;
    logic        busy;
    logic        frame_done;

    int   checks = 0;
    int   errors = 0;
    int   acks = 0;
    int   swaps = 0;
    int   fd_cnt = 0;
    int   m_base = 0, m_bx = 0, m_by = 0, m_row = 0, m_word = 0;
    int   exp_x = 0, exp_y = 0;
    logic prev_ber = 1'b0;
    exp_t sb[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h5a, a[15:8] + a[7:0]};
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    always #5 clk = ~clk;

    cur_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .data_out   (data_out),
        .counter    (counter),
        .ber        (ber),
        .pause_out  (pause_out),
        .blk_ready  (blk_ready),
        .blk_done   (blk_done),
        .blk_x      (blk_x),
        .blk_y      (blk_y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_counter", 32'(counter), 32'd0);
        chk("rst_ber", 32'(ber), 32'd0);
        chk("rst_pause", 32'(pause_out), 32'd1);
        chk("rst_blk_ready", 32'(blk_ready), 32'd0);
        chk("rst_blk_x", 32'(blk_x), 32'd0);
        chk("rst_blk_y", 32'(blk_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    // One clock: check registered outputs, then drive inputs and score any accepted read.
    task automatic tick(input logic ack, input logic done, input logic st);
        logic        rst_e;
        logic [15:0] exp_a;
        exp_t        e;
        rst_e = rst;
        @(posedge clk);
        #1;
        if (rst_e) begin
            sb.delete();
            prev_ber = ber;
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_data", 32'(data_out), 32'(e.data));
                chk("wr_counter", 32'(counter), 32'(e.slot));
                chk("wr_pause", 32'(pause_out), 32'd0);
            end else begin
                chk("idle_pause", 32'(pause_out), 32'd1);
            end
            if (ber !== prev_ber) begin
                swaps++;
                chk("swap_ready", 32'(blk_ready), 32'd1);
                chk("swap_blk_x", 32'(blk_x), 32'(exp_x));
                chk("swap_blk_y", 32'(blk_y), 32'(exp_y));
                chk("swap_pause", 32'(pause_out), 32'd1);
            end
            prev_ber = ber;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                chk("fd_busy", 32'(busy), 32'd0);
                chk("fd_ready", 32'(blk_ready), 32'd0);
            end
        end
        if (st && !busy && !rst) begin
            m_base = int'(base_addr);
            m_bx = 0; m_by = 0; m_row = 0; m_word = 0;
        end
        mem_ack  = ack;
        blk_done = done;
        start    = st;
        #1;
        if (mem_req && mem_ack && !rst) begin
            exp_a = 16'(m_base + (m_by * 8 + m_row) * FW + m_bx * 4 + m_word);
            chk("mem_addr", 32'(mem_addr), 32'(exp_a));
            if (m_bx == 0 && m_by == 0 && m_row == 0 && m_word == 0)
                chk("blk00_addr", 32'(mem_addr), 32'(16'(m_base)));
            if (m_bx == 0 && m_by == 1 && m_row == 0 && m_word == 0)
                chk("blk01_addr", 32'(mem_addr), 32'(16'(m_base + 704)));
            sb.push_back('{data: mem_word(exp_a), slot: 5'(m_row * 4 + m_word)});
            acks++;
            if (m_word == 3) begin
                m_word = 0;
                if (m_row == 7) begin
                    m_row = 0;
                    exp_x = m_bx;
                    exp_y = m_by;
                    if (m_bx == BC - 1) begin
                        m_bx = 0;
                        m_by++;
                    end else begin
                        m_bx++;
                    end
                end else begin
                    m_row++;
                end
            end else begin
                m_word++;
            end
        end
    endtask

    // mode 0: ack every cycle; mode 1: ack alternates 1,0.
    task automatic fill_until(input int target, input int mode);
        for (int i = 0; i < 400 && acks < target; i++) begin
            tick((mode == 0) ? 1'b1 : ~i[0], 1'b0, 1'b0);
        end
        if (acks < target) chk("fill_timeout", 32'(acks), 32'(target));
    endtask

    task automatic wait_swap(input int swaps_target);
        for (int i = 0; i < 20 && swaps < swaps_target; i++) tick(1'b0, 1'b0, 1'b0);
        if (swaps < swaps_target) chk("swap_timeout", 32'(swaps), 32'(swaps_target));
    endtask

    initial begin
        int a0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk_reset();
        rst = 1'b0;

        // Frame 1, block (0,0): base 0, ack tied high.
        base_addr = 16'h0000;
        tick(1'b0, 1'b0, 1'b1);
        a0 = acks;
        fill_until(a0 + 32, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("req_drop", 32'(mem_req), 32'd0);
        wait_swap(1);
        chk("b0_ber", 32'(ber), 32'd1);
        chk("b0_ready", 32'(blk_ready), 32'd1);
        chk("b0_x", 32'(blk_x), 32'd0);
        chk("b0_y", 32'(blk_y), 32'd0);

        // Block (1,0) with alternating ack and a start that must be ignored.
        a0 = acks;
        base_addr = 16'h5555;
        tick(1'b1, 1'b0, 1'b1);
        base_addr = 16'h0000;
        fill_until(a0 + 32, 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        chk("hold_req", 32'(mem_req), 32'd0);
        chk("hold_ber", 32'(ber), 32'd1);
        chk("hold_ready", 32'(blk_ready), 32'd1);
        chk("hold_swaps", 32'(swaps), 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("done_swap_ber", 32'(ber), 32'd0);
        chk("done_swap_ready", 32'(blk_ready), 32'd1);
        chk("done_swap_x", 32'(blk_x), 32'd1);
        chk("done_swaps", 32'(swaps), 32'd2);

        // Remainder of the frame with random ack and prompt blk_done.
        for (int i = 0; i < 40000 && fd_cnt == 0; i++) begin
            tick(1'($urandom_range(0, 3) != 0), blk_ready, 1'b0);
        end
        chk("frame_done_seen", 32'(fd_cnt), 32'd1);
        chk("frame_swaps", 32'(swaps), 32'd396);
        chk("frame_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
        chk("fd_once", 32'(fd_cnt), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_fd", 32'(frame_done), 32'd0);

        // Frame 2 aborted by reset at slot 17, then restarted.
        base_addr = 16'h1000;
        tick(1'b0, 1'b0, 1'b1);
        a0 = acks;
        fill_until(a0 + 18, 0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        chk_reset();
        rst = 1'b0;
        base_addr = 16'h0200;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("restart_ber", 32'(ber), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        a0 = acks;
        fill_until(a0 + 32, 0);
        wait_swap(397);
        chk("restart_swap_ber", 32'(ber), 32'd1);
        chk("restart_x", 32'(blk_x), 32'd0);
        chk("restart_y", 32'(blk_y), 32'd0);
        chk("fd_total", 32'(fd_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cur_fetch.md
CUR_FETCH -- requirements
Module: cur_fetch

Interface
REQ-001 Parameter FRAME_W_WORDS, default 88, frame line pitch in 16-bit words (176-pixel luma line).
REQ-002 Parameter BLK_COLS, default 22, 8x8 blocks per block row.
REQ-003 Parameter BLK_ROWS, default 18, block rows per frame.
REQ-004 Parameter ADDR_W, default 16, memory word-address width.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse: begin fetching a frame at base_addr.
REQ-008 base_addr  in  ADDR_W  word address of pixel (0,0), sampled on accepted start.
REQ-009 mem_req  out  1  read request.
REQ-010 mem_addr  out  ADDR_W  read word address.
REQ-011 mem_ack  in  1  read accepted; mem_rdata valid the same cycle.
REQ-012 mem_rdata  in  16  two pixels, upper byte = left pixel.
REQ-013 data_out  out  16  word to current-block register.
REQ-014 counter  out  5  word slot 0..31 (row*4 + word-in-row).
REQ-015 ber  out  1  bank select: 0 writes bank 1 and exposes bank 2; 1 the reverse.
REQ-016 pause_out  out  1  1 = no write this cycle.
REQ-017 blk_ready  out  1  level: exposed bank holds a complete block not yet consumed.
REQ-018 blk_done  in  1  one-cycle pulse from the SAD stage: exposed block consumed.
REQ-019 blk_x, blk_y  out  5 each  coordinates of the exposed block.
REQ-020 busy  out  1  high from accepted start until frame_done.
REQ-021 frame_done  out  1  one-cycle pulse after the last block is consumed.

Function
REQ-022 FSM states are IDLE, FILL, WAIT_SWAP and DRAIN.
REQ-023 IDLE: start moves to FILL with block (0,0); start while busy is ignored.
REQ-024 FILL: mem_req=1, mem_addr = base_addr + (by*8+row)*FRAME_W_WORDS + bx*4 + word, computed with an incremental row-base register (no multiplier).
REQ-025 Each mem_ack in FILL advances word 0..3, then row 0..7; mem_ack low holds the address.
REQ-026 data_out, counter and pause_out are registered together: one cycle after an ack, data_out=mem_rdata, counter=slot, pause_out=0; otherwise pause_out=1 and data_out/counter hold.
REQ-027 After the ack of slot 31, mem_req drops and the FSM enters WAIT_SWAP.
REQ-028 WAIT_SWAP swaps when blk_ready=0, or blk_done=1 in the same cycle, and never before slot 31's write cycle has passed.
REQ-029 A swap toggles ber, sets blk_ready=1, and loads blk_x/blk_y with the block just filled.
REQ-030 After a swap, the FSM advances to the next block in raster order (bx wraps at BLK_COLS-1, then by increments) and enters FILL; after the last block it enters DRAIN.
REQ-031 blk_done clears blk_ready unless a swap occurs the same cycle, in which case blk_ready stays 1.
REQ-032 blk_done with blk_ready=0 is ignored.
REQ-033 DRAIN: on blk_done, clear blk_ready, pulse frame_done, clear busy, and return to IDLE.
REQ-034 ber changes only while pause_out=1.

Reset
REQ-035 rst (sync, active-high) forces IDLE, mem_req=0, mem_addr=0, data_out=0, counter=0, ber=0, pause_out=1, blk_ready=0, blk_x=blk_y=0, busy=0, frame_done=0.
REQ-036 rst during any state aborts the frame without emitting frame_done.

Structure
REQ-037 A shared package holds the FSM state enumeration, the 8x8 block constants (8 rows, 4 words per row, 32 slots) and the parameter defaults.
REQ-038 One sub-module, cur_addr_gen, holds the block/row/word counters and the incremental address arithmetic; the FSM and handshake stay in cur_fetch.

Verification
REQ-039 start with base_addr=0 and mem_ack tied high -> first 32 addresses are 0,1,2,3,88,89,90,91,...,619; counters run 0..31 with pause_out=0; ber toggles to 1; blk_ready=1; blk_x=0, blk_y=0.
REQ-040 mem_ack toggling 1,0 -> pause_out=1 in each gap, counter never skips or repeats, and the 32 data_out words match memory.
REQ-041 blk_done withheld after the second block fills -> FSM holds in WAIT_SWAP with ber unchanged; blk_done pulse -> swap in that cycle and blk_ready stays 1.
REQ-042 Block (21,0) completes -> next fill starts at base_addr+704 for block (0,1).
REQ-043 Full 396-block frame with prompt blk_done -> exactly 396 swaps, frame_done pulses once, busy falls in the same cycle.
REQ-044 rst asserted at slot 17 -> all outputs take REQ-035 values next cycle; a new start refetches from block (0,0) with ber=0.
